// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between N producers.
// An owner keeps the port for up to MAX_BURST words, then ownership rotates.
module fifo_wr_arbiter #(
    parameter int N = 4,
    parameter int DW = 8,
    parameter int MAX_BURST = 4,
    localparam int IW = $clog2(N),
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] data,
    output logic [N-1:0]    ack,
    input  logic            fifo_full,
    output logic            fifo_wr,
    output logic [DW-1:0]   fifo_din,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_id
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] winner;
    logic [BW-1:0] beat;
    logic          any_req;
    logic          owner_req;
    logic [DW-1:0] owner_word;
    logic          busy;
    logic          last;

    // Lowest search offset from rr_ptr wins; later (smaller k) overrides.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && i == (int'(rr_ptr) + k) % N) begin
                    winner  = IW'(i);
                    any_req = 1'b1;
                end
            end
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_word = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == IW'(i)) begin
                owner_req  = req[i];
                owner_word = data[i*DW +: DW];
            end
        end
    end

    assign busy        = (state == BUSY);
    assign fifo_wr     = busy & owner_req & ~fifo_full;
    assign fifo_din    = busy ? owner_word : '0;
    assign grant_valid = busy;
    assign grant_id    = busy ? owner : '0;
    assign last        = (beat == BW'(MAX_BURST - 1));
    assign owner_nxt   = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

    always_comb begin
        ack = '0;
        for (int i = 0; i < N; i++)
            ack[i] = fifo_wr && (owner == IW'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            beat   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        beat  <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (fifo_wr)
                        beat <= beat + BW'(1);
                    // A full FIFO with req still held stalls in place.
                    if (fifo_wr ? last : !owner_req) begin
                        state  <= IDLE;
                        rr_ptr <= owner_nxt;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural grant model, FIFO model,
// directed scenarios with literal traces plus randomized traffic.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data = '0;
    logic [N-1:0]    ack;
    logic            fifo_full = 1'b0;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_din;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .data(data),
        .ack(ack),
        .fifo_full(fifo_full),
        .fifo_wr(fifo_wr),
        .fifo_din(fifo_din),
        .grant_valid(grant_valid),
        .grant_id(grant_id)
    );

    // Grant model: who owns the port, words taken so far, search start
    bit            m_busy;
    int            m_owner, m_words, m_next;
    logic [N-1:0]  m_ack;
    // FIFO model and requester bookkeeping
    logic [DW-1:0] fq[$];
    logic          rd = 1'b0;
    logic [DW-1:0] last_rd;
    bit            ro_chk = 0;
    int            seq[N];
    int            rd_seq[N];
    // Observed DUT outputs of the last stepped cycle
    logic          o_wr, o_gv;
    logic [DW-1:0] o_din;
    logic [IW-1:0] o_gid;
    logic [N-1:0]  o_ack;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_words = 0; m_next = 0; m_ack = '0;
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++)
            data[i*DW +: DW] = {2'(i), 6'(seq[i])};
    endtask

    // One clock: compare at negedge, advance models, return at posedge+1.
    task automatic step();
        logic [N-1:0]  e_ack;
        logic          e_wr;
        logic [DW-1:0] e_din;
        logic [IW-1:0] e_gid;
        logic [DW-1:0] v;
        int            id;
        @(negedge clk);
        e_ack = '0; e_wr = 0; e_din = '0; e_gid = '0;
        if (m_busy) begin
            e_gid = m_owner[IW-1:0];
            e_wr  = req[m_owner[IW-1:0]] && !fifo_full;
            e_din = DW'(data >> (m_owner * DW));
            e_ack[m_owner[IW-1:0]] = e_wr;
        end
        chk("outputs", {ack, fifo_wr, fifo_din, grant_valid, grant_id},
            {e_ack, e_wr, e_din, m_busy, e_gid});
        o_wr = fifo_wr; o_din = fifo_din; o_gv = grant_valid;
        o_gid = grant_id; o_ack = ack;
        m_ack = e_ack;
        if (rst) begin
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    int j = (m_next + k) % N;
                    if (req[j[IW-1:0]]) begin
                        m_busy = 1; m_owner = j; m_words = 0;
                        break;
                    end
                end
            end else if (e_wr) begin
                m_words++;
                if (m_words == MB) begin
                    m_busy = 0; m_next = (m_owner + 1) % N;
                end
            end else if (!req[m_owner[IW-1:0]]) begin
                m_busy = 0; m_next = (m_owner + 1) % N;
            end
        end
        if (e_wr) fq.push_back(e_din);
        else if (rd && fq.size() > 0) begin
            v = fq.pop_front();
            last_rd = v;
            if (ro_chk) begin
                id = int'(v[7:6]);
                chk("readback", v[5:0], rd_seq[id] % 64);
                rd_seq[id]++;
            end
        end
        for (int i = 0; i < N; i++) if (e_ack[i]) seq[i]++;
        @(posedge clk);
        #1;
        fifo_full = (fq.size() == 16);
    endtask

    task automatic do_reset();
        rst = 0; req = '0; rd = 0;
        model_reset();
        fq.delete();
        for (int i = 0; i < N; i++) begin seq[i] = 0; rd_seq[i] = 0; end
        drive_data();
        step(); step();
        fifo_full = 0;
        rst = 1;
    endtask

    task automatic drive_rand(int p_req, int p_rd);
        for (int i = 0; i < N; i++)
            if (!req[i] || m_ack[i])
                req[i] = ($urandom_range(0, 99) < p_req);
        drive_data();
        rd = ($urandom_range(0, 99) < p_rd);
    endtask

    initial begin
        logic [15:0]   gtr, wtr, itr;
        logic [DW-1:0] wq[$];
        logic [IW-1:0] gq[$];
        int            gw[8];
        int            n;
        longint        w;
        bit            pg;
        int            prd[6] = '{20, 90, 50, 5, 70, 40};
        int            prq[6] = '{60, 80, 30, 90, 50, 70};

        #2 rst = 0;
        #1 chk("reset_out", {ack, fifo_wr, fifo_din, grant_valid, grant_id}, 0);
        do_reset();

        // Single requester burst 0x10..0x14
        req = 4'b0001; data[7:0] = 8'h10; n = 0; gtr = 0; wtr = 0; wq.delete();
        for (int c = 0; c < 9; c++) begin
            step();
            gtr = {gtr[14:0], o_gv}; wtr = {wtr[14:0], o_wr};
            if (o_wr) wq.push_back(o_din);
            if (o_ack[0]) begin
                n++; data[7:0] = 8'h10 + 8'(n);
                if (n == 5) req[0] = 0;
            end
        end
        chk("t1_gv", gtr[8:0], 9'b011110110);
        chk("t1_wr", wtr[8:0], 9'b011110100);
        w = 0; foreach (wq[i]) w = (w << 8) | longint'(wq[i]);
        chk("t1_din", w, 40'h1011121314);

        // Rotation with req=1011
        do_reset(); rd = 1; req = 4'b1011; drive_data();
        gq.delete(); foreach (gw[i]) gw[i] = 0; n = 0; pg = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (o_gv && !pg) gq.push_back(o_gid);
            if (o_wr && gq.size() > 0 && gq.size() <= 8) gw[gq.size()-1]++;
            if (o_ack[2]) n++;
            pg = o_gv;
            drive_data();
        end
        chk("t2_grants", gq.size(), 4);
        w = 0; foreach (gq[i]) w = (w << 8) | longint'(gq[i]);
        chk("t2_order", w, 32'h00010300);
        chk("t2_words", {8'(gw[0]), 8'(gw[1]), 8'(gw[2]), 8'(gw[3])}, 32'h04040404);
        chk("t2_req2_acks", n, 0);

        // Early release by requester 2 while 3 waits
        do_reset(); rd = 1; req = 4'b1100; drive_data(); n = 0; gtr = 0; itr = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            gtr = {gtr[14:0], o_gv}; itr = {itr[13:0], o_gid};
            if (o_ack[2]) begin n++; if (n == 2) req[2] = 0; end
            drive_data();
        end
        chk("t3_acks2", n, 2);
        chk("t3_gv", gtr[6:0], 7'b0111011);
        chk("t3_gid", itr[13:0], 14'b00101010001111);

        // Full stall with 15 entries preloaded
        do_reset();
        for (int k = 0; k < 15; k++) fq.push_back(8'(k));
        fifo_full = 0; req = 4'b0010; data[15:8] = 8'hA0;
        n = 0; gtr = 0; wtr = 0; last_rd = '1;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) rd = 1;
            step();
            if (c == 4) rd = 0;
            gtr = {gtr[14:0], o_gv}; wtr = {wtr[14:0], o_wr};
            if (o_ack[1]) begin
                n++; data[15:8] = 8'hA0 + 8'(n);
                if (n == 2) req[1] = 0;
            end
        end
        chk("t4_wr", wtr[7:0], 8'b01000100);
        chk("t4_gv", gtr[7:0], 8'b01111110);
        chk("t4_pop", last_rd, 0);
        chk("t4_tail", {fq[14], fq[15]}, 16'hA0A1);

        // rr_ptr wrap after owner 3
        do_reset(); rd = 1; req = 4'b1000; drive_data(); gq.delete(); pg = 0;
        for (int c = 0; c < 13; c++) begin
            step();
            if (c == 0) req[0] = 1;
            if (o_gv && !pg) gq.push_back(o_gid);
            pg = o_gv;
            drive_data();
        end
        chk("t5_grants", gq.size(), 3);
        w = 0; foreach (gq[i]) w = (w << 8) | longint'(gq[i]);
        chk("t5_order", w, 24'h030003);

        // Reset in the middle of requester 2's burst
        do_reset(); rd = 1; req = 4'b0101; drive_data(); n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            step();
            if (o_ack[2]) n++;
            drive_data();
        end
        chk("rst_acks2", n, 2);
        #2 chk("pre_rst_wr", fifo_wr, 1);
        rst = 0; model_reset();
        #1 chk("rst_async", {ack, fifo_wr, fifo_din, grant_valid, grant_id}, 0);
        step(); rst = 1;
        step(); step();
        chk("rst_regrant", {o_gv, o_gid}, 3'b100);

        // Randomized traffic with varying read pressure
        do_reset(); ro_chk = 1;
        for (int b = 0; b < 6; b++)
            for (int c = 0; c < 400; c++) begin
                drive_rand(prq[b], prd[b]);
                step();
            end
        ro_chk = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the 16-deep, 8-bit FIFO between N requesters. A granted requester holds the port for a burst of up to MAX_BURST words, then ownership rotates. The block sits between the producer blocks and the FIFO's wr/din/full pins. It never drives the FIFO reset or read side.

Parameters:
N, 4, number of requesters (2..8)
DW, 8, data width; must match the FIFO din width
MAX_BURST, 4, maximum words written per grant (1..16)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
req  input  N  per-requester write request; held high while the requester has a word presented
data  input  N*DW  flattened per-requester words; requester i uses bits [i*DW +: DW]
ack  output  N  one-hot; ack[i]=1 in a cycle means the word on data[i] is written at this rising edge
fifo_full  input  1  FIFO full flag
fifo_wr  output  1  FIFO write strobe
fifo_din  output  DW  FIFO write data
grant_valid  output  1  high while a requester owns the port (BUSY)
grant_id  output  clog2(N)  current owner index; 0 when grant_valid=0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, owner=0, beat=0.
  - All outputs 0: ack, fifo_wr, fifo_din, grant_valid, grant_id.
  - Reset mid-burst abandons the burst immediately with no further write.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - fifo_wr=0, ack=0, fifo_din=0.
  - If any req is high, the winner is the first set req found searching from index rr_ptr upward, modulo N.
  - At the next edge: owner=winner, beat=0, state=BUSY.
  - Arbitration latency is one cycle from req rising to grant_valid rising.
  - fifo_full is not considered in IDLE.
- BUSY (combinational outputs):
  - fifo_wr = req[owner] & ~fifo_full.
  - fifo_din = data[owner].
  - ack[owner] = fifo_wr; all other ack bits are 0.
- BUSY (sequential, at each edge):
  - If fifo_wr=1: beat increments.
  - If fifo_wr=1 and beat==MAX_BURST-1, this is the last beat: go to IDLE and set rr_ptr=(owner+1) mod N.
  - Else if req[owner]=0: the burst ends early. Go to IDLE and set rr_ptr=(owner+1) mod N.
  - Else if fifo_full=1: stall. Hold owner and beat, write nothing. There is no timeout, and the owner keeps the grant.
- Requester rules:
  - Hold req and data stable until ack.
  - Dropping req between words ends the burst.
  - A requester may re-request in the cycle after ack.
- Rotation is strictly fair. After an owner finishes, it is searched last in the next arbitration. A lone requester may be re-granted after a single IDLE cycle.
- There is one mandatory IDLE cycle between grants, so the peak write rate is MAX_BURST words per MAX_BURST+1 cycles.
- The FIFO gives write priority over read when wr and !full are both true in the same cycle. Consumers must tolerate reads being ignored in cycles where fifo_wr=1. The arbiter does not mitigate this.
- beat is clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST-1 while in BUSY.

Test Plan:
- Reset mid-burst:
  - Stimulus: req=4'b0001, FIFO empty; drive rst low after 2 acks.
  - Required: outputs go to 0 asynchronously. After rst returns high, the first grant is to requester 0 again, because rr_ptr was reset.
- Single requester burst:
  - Stimulus: req=4'b0001 held, data0 = 0x10, 0x11, 0x12, 0x13, 0x14, FIFO empty.
  - Required: grant_valid rises 1 cycle after req. ack[0] pulses on 4 consecutive cycles writing 0x10..0x13, then 1 IDLE cycle, then 0x14 is written after re-grant.
- Round-robin rotation:
  - Stimulus: req=4'b1011 held, every requester has 4 words.
  - Required: grant order is 0, 1, 3, 0, with exactly 4 words per grant and requester 2 never acked.
- Early release:
  - Stimulus: requester 2 is owner and drops req after 2 words while requester 3 is requesting.
  - Required: exactly 2 acks to requester 2, then IDLE for 1 cycle, then grant_id=3.
- Full stall:
  - Stimulus: preload the FIFO to 15 entries. Requester 1 bursts 0xA0, 0xA1; consumer asserts rd 3 cycles later.
  - Required: 0xA0 is written and full goes to 1. fifo_wr stays 0 while full, with grant held and beat=1. After the read frees a slot, 0xA1 is written. FIFO read-back order is intact.
- Wrap of rr_ptr:
  - Stimulus: owner=3 finishes with req=4'b1001.
  - Required: the next grant is to 0 (rr_ptr wraps to 0), and requester 3 is re-granted only after requester 0 is served.
